// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a value source/consumer and the
// sequential binary-to-BCD converter. The source drives in_valid/bin and the
// consumer drives out_ready. The converter drives everything else.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     digit_en;
  logic                  ovf;
  logic                  busy;

  // Source/consumer side of the converter
  modport master (
    output in_valid,
    output bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd,
    input  digit_en,
    input  ovf,
    input  busy
  );

  // Converter side
  modport slave (
    input  in_valid,
    input  bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd,
    output digit_en,
    output ovf,
    output busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Captures a BIN_W-bit value, runs BIN_W double-dabble steps, then holds
// the packed BCD result with a leading-zero blanking mask and an overflow
// flag until the consumer accepts it. The BCD accumulator doubles as the
// registered bcd output, so it is stable for the whole hold phase.
module bin2bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  // A converter with no input bits or no digits makes no sense, so stop at elaboration
  generate
    if (BIN_W < 1 || DIGITS < 1) begin : g_param_check
      $fatal(1, "bin2bcd_seq: BIN_W and DIGITS must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t            state;
  logic [BIN_W-1:0]  sr;
  logic [BCD_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              ovf_q;
  logic [DIGITS-1:0] digit_en_q;

  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_next;
  logic              carry_out;
  logic [DIGITS-1:0] en_next;
  logic              any_nonzero;

  // One double-dabble step: correct every digit >=5 by +3 on the pre-shift
  // value, then shift the next binary MSB into the units digit. The bit that
  // falls off the top digit is what signals overflow.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
    end
    acc_next  = {acc_adj[BCD_W-2:0], sr[BIN_W-1]};
    carry_out = acc_adj[BCD_W-1];
  end

  // A digit is significant when it or any digit above it is nonzero; the
  // units digit is always shown so that zero displays as "0"
  always_comb begin
    any_nonzero = 1'b0;
    en_next     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nonzero = any_nonzero | (|acc_next[4*k +: 4]);
      en_next[k]  = any_nonzero;
    end
    en_next[0] = 1'b1;
  end

  // Control FSM with registered handshake outputs; reset aborts any
  // conversion or held result so it is never presented
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sr          <= '0;
      acc         <= '0;
      count       <= '0;
      ovf_q       <= 1'b0;
      digit_en_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr         <= bus.bin;
            acc        <= '0;
            ovf_q      <= 1'b0;
            count      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          acc   <= acc_next;
          sr    <= sr << 1;
          count <= count + CNT_W'(1);
          if (carry_out) begin
            ovf_q <= 1'b1;
          end
          if (count == LAST_STEP) begin
            digit_en_q  <= en_next;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.bcd       = acc;
  assign bus.digit_en  = digit_en_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a default 10-bit/4-digit instance and
// an 8-bit/2-digit instance that overflows, driven by directed vectors plus
// a back-to-back sweep of every 10-bit value.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(10), .DIGITS(4)) a ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) b ();

  bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    int          value;
    logic [31:0] bcd;
    logic [31:0] en;
    logic [31:0] ovf;
  } vec_t;

  // Counts one comparison and reports it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers one value to the selected instance, then counts the edges from
  // the capture edge until out_valid is seen
  task automatic applyStimulus(input int sel, input int value, output int latency);
    @(negedge clk);
    if (sel == 0) begin
      a.bin      = 10'(value);
      a.in_valid = 1'b1;
    end else begin
      b.bin      = 8'(value);
      b.in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    checkOutput($sformatf("busy_during_%0d", value),
                32'((sel == 0) ? a.busy : b.busy), 32'd1);
    latency = 0;
    while (!((sel == 0) ? a.out_valid : b.out_valid) && latency < 40) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
    end
  endtask

  // Accepts the held result with a one-cycle out_ready pulse
  task automatic acceptResult(input int sel);
    @(negedge clk);
    if (sel == 0) a.out_ready = 1'b1;
    else          b.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.out_ready = 1'b0;
    b.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] refBcd(input int v);
    logic [31:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (32'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] refEn(input int v);
    if (v >= 1000)     return 32'h0000000F;
    else if (v >= 100) return 32'h00000007;
    else if (v >= 10)  return 32'h00000003;
    else               return 32'h00000001;
  endfunction

  // Hard stop in case the design never finishes a handshake
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence followed by the exhaustive sweep
  initial begin
    vec_t        vecs_a [4];
    vec_t        vecs_b [4];
    int          lat;
    int          next_v;
    int          got_n;
    int          last_c;
    logic [31:0] held;

    vecs_a[0] = '{1023, 32'h1023, 32'hF, 32'd0};
    vecs_a[1] = '{0,    32'h0000, 32'h1, 32'd0};
    vecs_a[2] = '{7,    32'h0007, 32'h1, 32'd0};
    vecs_a[3] = '{305,  32'h0305, 32'h7, 32'd0};

    vecs_b[0] = '{255,  32'h55, 32'h3, 32'd1};
    vecs_b[1] = '{99,   32'h99, 32'h3, 32'd0};
    vecs_b[2] = '{100,  32'h00, 32'h1, 32'd1};
    vecs_b[3] = '{5,    32'h05, 32'h1, 32'd0};

    a.in_valid = 1'b0; a.bin = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.bin = '0; b.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_in_ready",  32'(a.in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(a.out_valid), 32'd0);
    checkOutput("rst_busy",      32'(a.busy),      32'd0);
    checkOutput("rst_bcd",       32'(a.bcd),       32'd0);
    checkOutput("rst_digit_en",  32'(a.digit_en),  32'd0);
    checkOutput("rst_ovf",       32'(a.ovf),       32'd0);
    checkOutput("rst_b_in_ready", 32'(b.in_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, vecs_a[i].value, lat);
      checkOutput($sformatf("a_latency_%0d", vecs_a[i].value), 32'(lat), 32'd10);
      checkOutput($sformatf("a_bcd_%0d", vecs_a[i].value), 32'(a.bcd), vecs_a[i].bcd);
      checkOutput($sformatf("a_en_%0d", vecs_a[i].value), 32'(a.digit_en), vecs_a[i].en);
      checkOutput($sformatf("a_ovf_%0d", vecs_a[i].value), 32'(a.ovf), vecs_a[i].ovf);
      checkOutput($sformatf("a_hold_busy_%0d", vecs_a[i].value), 32'(a.busy), 32'd0);
      checkOutput($sformatf("a_hold_in_ready_%0d", vecs_a[i].value), 32'(a.in_ready), 32'd0);
      acceptResult(0);
      checkOutput($sformatf("a_idle_in_ready_%0d", vecs_a[i].value), 32'(a.in_ready), 32'd1);
      checkOutput($sformatf("a_idle_out_valid_%0d", vecs_a[i].value), 32'(a.out_valid), 32'd0);
    end

    applyStimulus(0, 512, lat);
    held = 32'h0512;
    for (int i = 0; i < 20; i++) begin
      a.in_valid = 1'b1;
      a.bin      = 10'd77;
      checkOutput("bp_bcd",       32'(a.bcd),       held);
      checkOutput("bp_out_valid", 32'(a.out_valid), 32'd1);
      checkOutput("bp_in_ready",  32'(a.in_ready),  32'd0);
      @(negedge clk);
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.out_ready = 1'b0;
    checkOutput("bp_release_in_ready",  32'(a.in_ready),  32'd1);
    checkOutput("bp_release_out_valid", 32'(a.out_valid), 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("bp_not_queued_valid", 32'(a.out_valid), 32'd0);
    checkOutput("bp_not_queued_busy",  32'(a.busy),      32'd0);

    @(negedge clk);
    a.bin      = 10'd999;
    a.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out_valid", 32'(a.out_valid), 32'd0);
    checkOutput("abort_in_ready",  32'(a.in_ready),  32'd1);
    checkOutput("abort_bcd",       32'(a.bcd),       32'd0);
    checkOutput("abort_busy",      32'(a.busy),      32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("abort_no_result", 32'(a.out_valid), 32'd0);
    end
    applyStimulus(0, 42, lat);
    checkOutput("after_abort_latency", 32'(lat),        32'd10);
    checkOutput("after_abort_bcd",     32'(a.bcd),      32'h0042);
    checkOutput("after_abort_en",      32'(a.digit_en), 32'h3);
    acceptResult(0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, vecs_b[i].value, lat);
      checkOutput($sformatf("b_latency_%0d", vecs_b[i].value), 32'(lat), 32'd8);
      checkOutput($sformatf("b_bcd_%0d", vecs_b[i].value), 32'(b.bcd), vecs_b[i].bcd);
      checkOutput($sformatf("b_en_%0d", vecs_b[i].value), 32'(b.digit_en), vecs_b[i].en);
      checkOutput($sformatf("b_ovf_%0d", vecs_b[i].value), 32'(b.ovf), vecs_b[i].ovf);
      acceptResult(1);
    end

    a.out_ready = 1'b1;
    a.in_valid  = 1'b0;
    next_v = 0;
    got_n  = 0;
    last_c = -1;
    for (int c = 0; c < 14000 && got_n < 1024; c++) begin
      @(negedge clk);
      if (a.out_valid) begin
        checkOutput($sformatf("sweep_bcd_%0d", got_n), 32'(a.bcd), refBcd(got_n));
        checkOutput($sformatf("sweep_en_%0d", got_n), 32'(a.digit_en), refEn(got_n));
        checkOutput($sformatf("sweep_ovf_%0d", got_n), 32'(a.ovf), 32'd0);
        if (last_c >= 0) begin
          checkOutput($sformatf("sweep_spacing_%0d", got_n), 32'(c - last_c), 32'd12);
        end
        last_c = c;
        got_n++;
      end
      if (a.in_ready && next_v < 1024) begin
        a.in_valid = 1'b1;
        a.bin      = 10'(next_v);
        next_v++;
      end else begin
        a.in_valid = 1'b0;
      end
    end
    checkOutput("sweep_count", 32'(got_n), 32'd1024);
    a.out_ready = 1'b0;
    a.in_valid  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It succeeds the fixed 10-bit/3-digit combinational converter and adds:
- generic input width and digit count
- a valid/ready handshake on both sides
- overflow detection
- a leading-zero blanking mask for the 7-segment digit drivers

It sits between the value source (counter/ALU) and the 7-segment multiplexer.

Parameters:
BIN_W, 10, binary input width in bits (>=1).
DIGITS, 4, number of BCD output digits (>=1); bcd width = 4*DIGITS.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  bin is valid for conversion.
in_ready  out  1  converter can accept a new value.
bin  in  BIN_W  unsigned binary value.
out_valid  out  1  bcd/digit_en/ovf are valid.
out_ready  in  1  consumer accepts the result.
bcd  out  4*DIGITS  packed BCD; digit 0 (units) in bcd[3:0].
digit_en  out  DIGITS  1 = digit is significant (leading-zero blanking).
ovf  out  1  value did not fit in DIGITS digits.
busy  out  1  conversion in progress.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state IDLE; in_ready=1; out_valid=0; busy=0
  - bcd=0; digit_en=0; ovf=0; shift count=0
- Reset mid-conversion or while holding a result aborts it; the result is never presented.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture bin into the shift register, clear the BCD accumulator and ovf, set count=0, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1. Each cycle performs one step.
  - Step part 1: every accumulator digit >=5 gets +3 (all digits corrected in parallel, on pre-shift values).
  - Step part 2: {accumulator, shift register} shifts left by 1; MSB of bin enters digit 0 bit 0.
  - Step part 3: if the bit shifted out of the top digit is 1, ovf is set (sticky until next capture).
  - After the BIN_W-th step, go to HOLD.
- Latency: out_valid rises exactly BIN_W clock edges after the capture edge.
- HOLD:
  - out_valid=1, busy=0, in_ready=0.
  - bcd, digit_en and ovf are stable for the whole hold.
  - On an edge with out_ready=1: out_valid=0, return to IDLE.
  - out_ready held high continuously gives throughput of one conversion per BIN_W+2 cycles.
- Registered outputs: bcd, digit_en and ovf are registered. Their values outside HOLD are don't-care, but they must not glitch during HOLD.
- digit_en[k] = 1 if any digit j>=k is nonzero. digit_en[0] is always 1 in HOLD, so zero shows as "0".
- ovf:
  - ovf=1 means bcd holds the value modulo 10^DIGITS; the lower digits remain correct.
  - digit_en is computed on the truncated digits.
- in_valid outside IDLE is ignored; no value is queued.
- out_ready outside HOLD is ignored.
- Elaboration check: BIN_W<1 or DIGITS<1 is a fatal error. Insufficient DIGITS is legal and is reported at runtime via ovf.

Test Plan:
- Default params, bin=1023 with in_valid → out_valid exactly 10 edges after capture; bcd=0x1023, digit_en=4'b1111, ovf=0.
- bin=0 → bcd=0x0000, digit_en=4'b0001. bin=7 → bcd=0x0007, digit_en=4'b0001. bin=305 → bcd=0x0305, digit_en=4'b0111.
- Backpressure: out_ready=0 for 20 cycles after out_valid → bcd stable, in_ready=0, new in_valid ignored. Then out_ready=1 for one cycle → IDLE next cycle, in_ready=1.
- rst pulsed at step 5 of a conversion of 999 → next cycle out_valid=0, in_ready=1, bcd=0; new value 42 then converts to 0x0042.
- BIN_W=8, DIGITS=2, bin=255 → bcd=0x55, ovf=1. bin=99 → bcd=0x99, ovf=0.
- Exhaustive sweep, default params, bin 0..1023 back-to-back with out_ready=1 → each bcd matches the decimal reference, ovf=0, and the spacing between out_valid pulses is 12 cycles.
